// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter handing the shared system bus to one of
// NUM_MASTER masters. Requests and grants are active-low.
//
// Optional feature: define BUS_ARB_TIMEOUT_EN to enable the hold counter,
// which forces a handover after TIMEOUT_CYCLES consecutive grant cycles
// whenever another master is waiting. Without the macro the owner keeps
// the bus until it releases, and timeout is tied to 0.

module bus_arbiter #(
    parameter int NUM_MASTER     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_MASTER-1:0]         m_reqn,
    output logic [NUM_MASTER-1:0]         m_grntn,
    output logic [$clog2(NUM_MASTER)-1:0] owner,
    output logic                          busy,
    output logic                          timeout
);

    localparam int IDX_W = $clog2(NUM_MASTER);

    // Elaboration guard: the modulo search relies on a power-of-two count,
    // and the hold counter is only 8 bits wide.
    if ((NUM_MASTER < 2) || (NUM_MASTER > 8) ||
        ((NUM_MASTER & (NUM_MASTER - 1)) != 0)) begin : g_bad_num_master
        $error("bus_arbiter: NUM_MASTER must be a power of two in 2..8");
    end
    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYCLES must be in 2..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      ptr_nxt;
    logic [IDX_W-1:0]      owner_q;
    logic [IDX_W-1:0]      owner_nxt;
    logic [NUM_MASTER-1:0] grntn_q;
    logic [NUM_MASTER-1:0] grntn_nxt;

    logic [NUM_MASTER-1:0] req;
    logic [NUM_MASTER-1:0] other_req;
    logic [NUM_MASTER-1:0] search_req;
    logic [IDX_W-1:0]      sel;
    logic                  owner_release;
    logic                  hold_expired;
    logic                  force_handover;

    // One-hot decode of a master index.
    function automatic logic [NUM_MASTER-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_MASTER-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First set bit of req, scanning start, start+1, ... with natural
    // wrap because the index width exactly covers NUM_MASTER.
    function automatic logic [IDX_W-1:0] pick_first(input logic [NUM_MASTER-1:0] r,
                                                    input logic [IDX_W-1:0]      start);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] res;
        found = 1'b0;
        res   = start;
        for (int i = 0; i < NUM_MASTER; i++) begin
            idx = start + IDX_W'(i);
            if (!found && r[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // Active-high request view; the current owner is masked out so it is
    // never re-selected on its own release or forced-handover cycle.
    always_comb begin
        req        = ~m_reqn;
        other_req  = req & ~onehot(owner_q);
        search_req = (state == IDLE) ? req : other_req;
        sel        = pick_first(search_req, ptr);
        owner_release  = m_reqn[owner_q];
        force_handover = hold_expired && (|other_req);
    end

`ifdef BUS_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] hold_cnt;
    logic       new_grant;
    logic       timeout_q;

    assign hold_expired = (state == GRANT) && (hold_cnt == HOLD_LIMIT);
    assign new_grant    = (state_nxt == GRANT) &&
                          ((state == IDLE) || (owner_nxt != owner_q));

    // Hold counter: restarts on every fresh grant, counts grant cycles and
    // parks at the limit so a late-arriving requester is served promptly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_cnt <= 8'd0;
        end else if (new_grant) begin
            hold_cnt <= 8'd0;
        end else if ((state == GRANT) && (hold_cnt != HOLD_LIMIT)) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    // Timeout pulse is registered alongside the forced grant change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= force_handover;
        end
    end

    assign timeout = timeout_q;
`else
    assign hold_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    // Next-state and next-grant decision for the IDLE/GRANT machine.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner_q;
        grntn_nxt = grntn_q;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = GRANT;
                    owner_nxt = sel;
                    ptr_nxt   = sel + IDX_W'(1);
                    grntn_nxt = ~onehot(sel);
                end
            end
            GRANT: begin
                if (owner_release || force_handover) begin
                    if (|other_req) begin
                        owner_nxt = sel;
                        ptr_nxt   = sel + IDX_W'(1);
                        grntn_nxt = ~onehot(sel);
                    end else begin
                        state_nxt = IDLE;
                        grntn_nxt = '1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grntn_nxt = '1;
            end
        endcase
    end

    // State, pointer, owner and grant registers; reset drops any grant at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            owner_q <= '0;
            grntn_q <= '1;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            owner_q <= owner_nxt;
            grntn_q <= grntn_nxt;
        end
    end

    assign m_grntn = grntn_q;
    assign owner   = owner_q;
    assign busy    = (state == GRANT);

endmodule
